// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812b frame sequencer.
package ws2812_pkg;

    localparam int unsigned PIXEL_W              = 24;
    localparam int unsigned LATCH_CYCLES_DEFAULT = 6000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StOffer,
        StDrain,
        StLatch
    } state_e;

endpackage

// File: rtl/ws2812_latch_timer.sv
// Load/decrement down-counter that times the WS2812b latch gap.
// o_done is high while the count sits at zero.
module ws2812_latch_timer
    import ws2812_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    localparam int unsigned     CNT_W    = $clog2(LATCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATCH_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Walks the pixel ROM for one frame, hands pixels to the WS2812b encoder over valid/ready,
// then waits for the line to drain and the latch gap. Optional FRAME_SEQ_ROTATE_EN: chase offset.
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned NUM_LEDS     = 32,
    parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [PIXEL_W-1:0]    i_rom_data,
    output logic [PIXEL_W-1:0]    o_pixel_data,
    output logic                  o_pixel_valid,
    input  logic                  i_pixel_ready,
    input  logic                  i_tx_idle,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int unsigned       IDX_W    = ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LEDS - 1);

    state_e                r_state;
    logic [IDX_W-1:0]      r_index;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [PIXEL_W-1:0]    r_pixel_data;
    logic                  r_pixel_valid;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [IDX_W-1:0]      w_index_inc;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_latch_load;
    logic                  w_latch_dec;
    logic                  w_latch_done;

`ifdef FRAME_SEQ_ROTATE_EN
    logic [ADDR_WIDTH-1:0] r_offset;

    // Offset steps exactly when the frame-done pulse is emitted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_offset <= '0;
        end else if (o_frame_done) begin
            r_offset <= r_offset + ADDR_WIDTH'(1);
        end
    end

    assign w_offset = r_offset;
`else
    assign w_offset = '0;
`endif

    assign w_index_inc = r_index + IDX_W'(1);
    assign w_next_addr = w_offset + ADDR_WIDTH'(w_index_inc);

    assign w_latch_load = (r_state == StDrain) && i_tx_idle;
    assign w_latch_dec  = (r_state == StLatch);

    ws2812_latch_timer #(
        .LATCH_CYCLES (LATCH_CYCLES)
    ) u_latch_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_latch_load),
        .i_dec  (w_latch_dec),
        .o_done (w_latch_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_index       <= '0;
            r_rom_addr    <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_enable) begin
                        r_index    <= '0;
                        r_rom_addr <= w_offset;
                        r_state    <= StFetch;
                    end
                end
                StFetch: begin
                    r_pixel_data  <= i_rom_data;
                    r_pixel_valid <= 1'b1;
                    r_state       <= StOffer;
                end
                StOffer: begin
                    if (r_pixel_valid && i_pixel_ready) begin
                        r_pixel_valid <= 1'b0;
                        if (r_index == LAST_IDX) begin
                            r_state <= StDrain;
                        end else begin
                            r_index    <= w_index_inc;
                            r_rom_addr <= w_next_addr;
                            r_state    <= StFetch;
                        end
                    end
                end
                StDrain: begin
                    if (i_tx_idle) begin
                        r_state <= StLatch;
                    end
                end
                StLatch: begin
                    if (w_latch_done) begin
                        r_index <= '0;
`ifdef FRAME_SEQ_ROTATE_EN
                        r_rom_addr <= w_offset + ADDR_WIDTH'(1);
`else
                        r_rom_addr <= w_offset;
`endif
                        r_state <= i_enable ? StFetch : StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_rom_addr    = r_rom_addr;
    assign o_pixel_data  = r_pixel_data;
    assign o_pixel_valid = r_pixel_valid;
    assign o_busy        = (r_state != StIdle);
    assign o_frame_done  = (r_state == StLatch) && w_latch_done;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer (NUM_LEDS=4, LATCH_CYCLES=10).
// Build with FRAME_SEQ_ROTATE_EN to expect the chase offset across frames.
module tb_ws2812_frame_sequencer;

    localparam int unsigned AW = 5;
`ifdef FRAME_SEQ_ROTATE_EN
    localparam int ROT = 1;
`else
    localparam int ROT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data;
    logic [23:0]   pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          tx_idle;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 1000;

    logic        obs_valid [64];
    logic [23:0] obs_data  [64];
    logic [AW-1:0] obs_addr [64];
    logic        obs_busy  [64];
    logic        obs_done  [64];
    int          xfer_cyc  [$];
    int          xfer_data [$];
    int          done_cyc  [$];

    always #5 clk = ~clk;

    assign rom_data = {3'b000, rom_addr, 16'hA5A5};

    ws2812_frame_sequencer #(
        .ADDR_WIDTH   (AW),
        .NUM_LEDS     (4),
        .LATCH_CYCLES (10)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_pixel_data  (pixel_data),
        .o_pixel_valid (pixel_valid),
        .i_pixel_ready (pixel_ready),
        .i_tx_idle     (tx_idle),
        .o_busy        (busy),
        .o_frame_done  (frame_done)
    );

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < 64) begin
            obs_valid[cyc] = pixel_valid;
            obs_data[cyc]  = pixel_data;
            obs_addr[cyc]  = rom_addr;
            obs_busy[cyc]  = busy;
            obs_done[cyc]  = frame_done;
            if (pixel_valid && pixel_ready) begin
                xfer_cyc.push_back(cyc);
                xfer_data.push_back(int'(pixel_data));
            end
            if (frame_done) done_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_get(input int q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // Cycle 0 is the IDLE cycle in which enable first goes high.
    task automatic run_frame(input int rdy_from, input int rdy_len, input int idl_from,
                             input int idl_len, input int en_drop, input int rst_at,
                             input int ncyc);
        xfer_cyc.delete();
        xfer_data.delete();
        done_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            cyc         = c;
            pixel_ready = !(c >= rdy_from && c < rdy_from + rdy_len);
            tx_idle     = !(c >= idl_from && c < idl_from + idl_len);
            enable      = (c < en_drop);
            rst         = (c == rst_at);
            @(posedge clk);
            #1;
        end
        cyc         = 1000;
        enable      = 1'b0;
        rst         = 1'b0;
        pixel_ready = 1'b1;
        tx_idle     = 1'b1;
    endtask

    initial begin
        int err;
        rst         = 1'b1;
        enable      = 1'b0;
        pixel_ready = 1'b1;
        tx_idle     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_addr",  32'(rom_addr),    32'h0);
        check_eq("rst_data",  32'(pixel_data),  32'h0);
        check_eq("rst_valid", 32'(pixel_valid), 32'h0);
        check_eq("rst_busy",  32'(busy),        32'h0);
        check_eq("rst_done",  32'(frame_done),  32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Free-running frame: transfers every 2 cycles, done at cycle 19.
        run_frame(0, 0, 0, 0, 19, -1, 21);
        check_eq("t1_nxfer", 32'(xfer_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t1_xcyc%0d", k), q_get(xfer_cyc, k), 2 + 2 * k);
            check_eq($sformatf("t1_xdat%0d", k), q_get(xfer_data, k), {8'(k), 16'hA5A5});
        end
        check_eq("t1_ndone", 32'(done_cyc.size()), 32'd1);
        check_eq("t1_done_cyc", q_get(done_cyc, 0), 32'd19);
        err = 0;
        for (int c = 1; c <= 19; c++) if (obs_busy[c] !== 1'b1) err++;
        check_eq("t1_busy_hi", err, 0);
        check_eq("t1_busy_idle", 32'(obs_busy[20]), 32'h0);

        // Ready stalled during pixel 1 for 5 cycles.
        run_frame(4, 5, 0, 0, 24, -1, 26);
        check_eq("t2_nxfer", 32'(xfer_cyc.size()), 32'd4);
        check_eq("t2_xcyc1", q_get(xfer_cyc, 1), 32'd9);
        err = 0;
        for (int c = 4; c <= 8; c++) begin
            if (obs_valid[c] !== 1'b1 || obs_data[c] !== 24'h01A5A5) err++;
        end
        check_eq("t2_stable", err, 0);
        check_eq("t2_done_cyc", q_get(done_cyc, 0), 32'd24);

        // tx_idle low for 7 cycles after the last transfer.
        run_frame(0, 0, 9, 7, 26, -1, 28);
        check_eq("t3_nxfer", 32'(xfer_cyc.size()), 32'd4);
        check_eq("t3_ndone", 32'(done_cyc.size()), 32'd1);
        check_eq("t3_done_cyc", q_get(done_cyc, 0), 32'd26);

        // Enable dropped after pixel 0: frame still completes, then IDLE.
        run_frame(0, 0, 0, 0, 5, -1, 25);
        check_eq("t4_nxfer", 32'(xfer_cyc.size()), 32'd4);
        check_eq("t4_xdat3", q_get(xfer_data, 3), 32'h03A5A5);
        check_eq("t4_ndone", 32'(done_cyc.size()), 32'd1);
        check_eq("t4_done_cyc", q_get(done_cyc, 0), 32'd19);
        check_eq("t4_busy_end", 32'(obs_busy[24]), 32'h0);

        // Reset while pixel 1 is offered; enable stays high so it restarts at address 0.
        run_frame(4, 1, 0, 0, 24, 4, 26);
        check_eq("t5_addr",  32'(obs_addr[5]),  32'h0);
        check_eq("t5_data",  32'(obs_data[5]),  32'h0);
        check_eq("t5_valid", 32'(obs_valid[5]), 32'h0);
        check_eq("t5_busy",  32'(obs_busy[5]),  32'h0);
        check_eq("t5_done",  32'(obs_done[5]),  32'h0);
        check_eq("t5_nxfer", 32'(xfer_cyc.size()), 32'd5);
        check_eq("t5_xcyc1", q_get(xfer_cyc, 1), 32'd7);
        check_eq("t5_xdat1", q_get(xfer_data, 1), 32'h00A5A5);
        check_eq("t5_done_cyc", q_get(done_cyc, 0), 32'd24);

        // Three back-to-back frames; start address follows the optional chase offset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(0, 0, 0, 0, 57, -1, 59);
        check_eq("t6_nxfer", 32'(xfer_cyc.size()), 32'd12);
        check_eq("t6_ndone", 32'(done_cyc.size()), 32'd3);
        check_eq("t6_done2", q_get(done_cyc, 2), 32'd57);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("t6_f%0d_p%0d", f, k), q_get(xfer_data, 4 * f + k),
                         {8'((ROT != 0 ? f : 0) + k), 16'hA5A5});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
